// File: rtl/wb_rr_arbiter_pkg.sv
// wb_rr_arbiter_pkg: shared widths, default master indices and FSM state type
package wb_rr_arbiter_pkg;
    localparam int GW = 3;
    localparam int WDW = 16;
    localparam int M_LM32I = 0;
    localparam int M_LM32D = 1;
    localparam int M_DBG = 2;
    typedef enum logic {IDLE, OWN} state_t;
endpackage

// File: rtl/wb_rr_arbiter_rr_pick.sv
// wb_rr_arbiter_rr_pick: rotating-priority encoder, nearest requester after last wins
module wb_rr_arbiter_rr_pick
    import wb_rr_arbiter_pkg::*;
#(
    parameter int N = 3
) (
    input  logic [N-1:0]  req,
    input  logic [GW-1:0] last,
    output logic [GW-1:0] idx,
    output logic          valid
);
    // pick the requester with the smallest rotational distance past last
    always_comb begin
        int best;
        best = N;
        idx = '0;
        for (int j = 0; j < N; j++) begin
            if (req[j] && ((j + N - int'(last) - 1) % N) < best) begin
                best = (j + N - int'(last) - 1) % N;
                idx = GW'(j);
            end
        end
        valid = |req;
    end
endmodule

// File: rtl/wb_rr_arbiter.sv
// wb_rr_arbiter: round-robin Wishbone classic arbiter with bus watchdog
module wb_rr_arbiter
    import wb_rr_arbiter_pkg::*;
#(
    parameter int NUM_MASTERS = 3,
    parameter int ADR_WIDTH = 32,
    parameter int DAT_WIDTH = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [NUM_MASTERS-1:0]             m_cyc,
    input  logic [NUM_MASTERS-1:0]             m_stb,
    input  logic [NUM_MASTERS-1:0]             m_we,
    input  logic [NUM_MASTERS*ADR_WIDTH-1:0]   m_adr,
    input  logic [NUM_MASTERS*DAT_WIDTH/8-1:0] m_sel,
    input  logic [NUM_MASTERS*DAT_WIDTH-1:0]   m_dat_w,
    output logic [DAT_WIDTH-1:0]               m_dat_r,
    output logic [NUM_MASTERS-1:0]             m_ack,
    output logic [NUM_MASTERS-1:0]             m_err,
    output logic                               s_cyc,
    output logic                               s_stb,
    output logic                               s_we,
    output logic [ADR_WIDTH-1:0]               s_adr,
    output logic [DAT_WIDTH/8-1:0]             s_sel,
    output logic [DAT_WIDTH-1:0]               s_dat_w,
    input  logic [DAT_WIDTH-1:0]               s_dat_r,
    input  logic                               s_ack,
    input  logic                               s_err,
    output logic [2:0]                         grant,
    output logic                               busy,
    output logic                               timeout
);
    localparam int SW = DAT_WIDTH / 8;
    state_t state;
    logic [GW-1:0] last;
    logic [GW-1:0] pick;
    logic pick_valid;
    logic [WDW-1:0] wd;
    logic wd_fire;
    wb_rr_arbiter_rr_pick #(.N(NUM_MASTERS)) u_pick (
        .req(m_cyc),
        .last(last),
        .idx(pick),
        .valid(pick_valid)
    );
    assign wd_fire = (TIMEOUT != 0) && s_cyc && s_stb && !s_ack && !s_err && wd == WDW'(TIMEOUT - 1);
    assign timeout = wd_fire;
    assign m_dat_r = s_dat_r;
    // forward the owner's request to the slave; everything stays low while idle
    always_comb begin
        s_cyc = 1'b0;
        s_stb = 1'b0;
        s_we = 1'b0;
        s_adr = '0;
        s_sel = '0;
        s_dat_w = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (busy && grant == GW'(i)) begin
                s_cyc = m_cyc[i];
                s_stb = m_stb[i];
                s_we = m_we[i];
                s_adr = m_adr[i*ADR_WIDTH +: ADR_WIDTH];
                s_sel = m_sel[i*SW +: SW];
                s_dat_w = m_dat_w[i*DAT_WIDTH +: DAT_WIDTH];
            end
        end
    end
    // deliver ack/err only to the current owner; a pending ack suppresses the watchdog
    always_comb begin
        m_ack = '0;
        m_err = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (busy && grant == GW'(i)) begin
                m_ack[i] = s_ack;
                m_err[i] = s_err | wd_fire;
            end
        end
    end
    // ownership FSM plus watchdog; release when the owner drops cyc, remembering it for rotation
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            busy <= 1'b0;
            grant <= '0;
            last <= GW'(NUM_MASTERS - 1);
            wd <= '0;
        end else begin
            wd <= (s_cyc && s_stb && !s_ack && !s_err && !wd_fire) ? wd + 1'b1 : '0;
            if (state == IDLE) begin
                if (pick_valid) begin
                    grant <= pick;
                    busy <= 1'b1;
                    state <= OWN;
                end
            end else if (!s_cyc) begin
                last <= grant;
                busy <= 1'b0;
                state <= IDLE;
            end
        end
    end
endmodule

// File: tb/tb_wb_rr_arbiter.sv
// tb_wb_rr_arbiter: scoreboard bench for grant order, routing, watchdog and reset
module tb_wb_rr_arbiter;
    import wb_rr_arbiter_pkg::*;
    typedef struct {
        logic [2:0]  v;
        logic [31:0] d;
    } exp_t;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  m_cyc = '0;
    logic [2:0]  m_stb = '0;
    logic [2:0]  m_we = '0;
    logic [95:0] m_adr = '0;
    logic [11:0] m_sel = '0;
    logic [95:0] m_dat_w = '0;
    logic [31:0] m_dat_r;
    logic [2:0]  m_ack;
    logic [2:0]  m_err;
    logic        s_cyc;
    logic        s_stb;
    logic        s_we;
    logic [31:0] s_adr;
    logic [3:0]  s_sel;
    logic [31:0] s_dat_w;
    logic [31:0] s_dat_r = '0;
    logic        s_ack = 1'b0;
    logic        s_err = 1'b0;
    logic [2:0]  grant;
    logic        busy;
    logic        timeout;
    int total = 0;
    int bad = 0;
    int gq[$];
    exp_t aq[$];
    logic [3:0] eq[$];
    logic busy_q = 1'b0;

    wb_rr_arbiter #(.NUM_MASTERS(3), .ADR_WIDTH(32), .DAT_WIDTH(32), .TIMEOUT(16)) dut (
        .clk(clk), .reset(reset),
        .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we), .m_adr(m_adr), .m_sel(m_sel),
        .m_dat_w(m_dat_w), .m_dat_r(m_dat_r), .m_ack(m_ack), .m_err(m_err),
        .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr), .s_sel(s_sel),
        .s_dat_w(s_dat_w), .s_dat_r(s_dat_r), .s_ack(s_ack), .s_err(s_err),
        .grant(grant), .busy(busy), .timeout(timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic wait_busy(input string tag);
        int n;
        n = 0;
        @(negedge clk);
        while (!busy && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 64'(busy), 64'(1));
    endtask

    task automatic serve(input int g, input logic [31:0] d, input bit rearm);
        wait_busy("serve_busy");
        @(posedge clk); #1;
        s_ack = 1'b1;
        s_dat_r = d;
        m_cyc[g] = 1'b0;
        m_stb[g] = 1'b0;
        aq.push_back('{3'(1 << g), d});
        @(posedge clk); #1;
        s_ack = 1'b0;
        if (rearm) begin
            m_cyc[g] = 1'b1;
            m_stb[g] = 1'b1;
        end
        @(negedge clk);
        chk("idle_gap", 64'(busy), 64'(0));
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (busy && !busy_q) begin
                if (gq.size() == 0) chk("grant_unexp", 64'(grant), 64'hFF);
                else chk("grant", 64'(grant), 64'(gq.pop_front()));
            end
            if (m_ack != 0) begin
                if (aq.size() == 0) chk("ack_unexp", 64'(m_ack), 64'(0));
                else begin
                    exp_t e;
                    e = aq.pop_front();
                    chk("ack", 64'(m_ack), 64'(e.v));
                    chk("dat_r", 64'(m_dat_r), 64'(e.d));
                end
            end
            if (m_err != 0 || timeout) begin
                if (eq.size() == 0) chk("err_unexp", 64'({m_err, timeout}), 64'(0));
                else chk("err", 64'({m_err, timeout}), 64'(eq.pop_front()));
            end
        end
        busy_q = busy;
    end

    initial begin
        #100000;
        $display("FAIL sim_timeout got=running exp=finished");
        $fatal(1, "bench time limit");
    end

    initial begin
        int fires, f1, f2;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_grant", 64'(grant), 64'(0));
        chk("rst_scyc", 64'(s_cyc), 64'(0));
        chk("rst_sstb", 64'(s_stb), 64'(0));
        chk("rst_ack", 64'(m_ack), 64'(0));
        chk("rst_err", 64'(m_err), 64'(0));
        chk("rst_to", 64'(timeout), 64'(0));

        // single master read with ack on the second strobe cycle
        @(posedge clk); #1;
        m_cyc[M_LM32D] = 1'b1;
        m_stb[M_LM32D] = 1'b1;
        m_adr[M_LM32D*32 +: 32] = 32'h0000_1000;
        m_sel[M_LM32D*4 +: 4] = 4'hF;
        gq.push_back(M_LM32D);
        @(negedge clk);
        chk("t1_lat", 64'(s_cyc), 64'(0));
        @(negedge clk);
        chk("t1_scyc", 64'(s_cyc), 64'(1));
        chk("t1_adr", 64'(s_adr), 64'h1000);
        chk("t1_we", 64'(s_we), 64'(0));
        chk("t1_sel", 64'(s_sel), 64'hF);
        @(posedge clk); #1;
        s_ack = 1'b1;
        s_dat_r = 32'hCAFE_F00D;
        aq.push_back('{3'b010, 32'hCAFE_F00D});
        @(negedge clk);
        chk("t1_ack", 64'(m_ack), 64'b010);
        @(posedge clk); #1;
        s_ack = 1'b0;
        m_cyc[M_LM32D] = 1'b0;
        m_stb[M_LM32D] = 1'b0;
        @(posedge clk); #1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("idle_busy", 64'(busy), 64'(0));
        chk("idle_grant", 64'(grant), 64'(1));

        // all masters request together right after reset
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        m_cyc = 3'b111;
        m_stb = 3'b111;
        gq.push_back(0); gq.push_back(1); gq.push_back(2); gq.push_back(0);
        serve(0, 32'hA000_0000, 1'b1);
        serve(1, 32'hA000_0001, 1'b0);
        serve(2, 32'hA000_0002, 1'b0);
        serve(0, 32'hA000_0003, 1'b0);

        // m0 holds the bus for four beats while m1 waits
        @(posedge clk); #1;
        m_cyc[M_LM32I] = 1'b1;
        m_stb[M_LM32I] = 1'b1;
        gq.push_back(M_LM32I);
        wait_busy("t3_busy");
        @(posedge clk); #1;
        m_cyc[M_LM32D] = 1'b1;
        m_stb[M_LM32D] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            s_ack = 1'b1;
            s_dat_r = 32'h100 + 32'(i);
            aq.push_back('{3'b001, 32'h100 + 32'(i)});
            @(negedge clk);
            chk("t3_hold", 64'(grant), 64'(0));
            @(posedge clk); #1;
        end
        s_ack = 1'b0;
        m_cyc[M_LM32I] = 1'b0;
        m_stb[M_LM32I] = 1'b0;
        gq.push_back(M_LM32D);
        @(negedge clk);
        chk("t3_rel_pend", 64'(busy), 64'(1));
        @(posedge clk); #1;
        serve(M_LM32D, 32'h1111_1111, 1'b0);

        // watchdog with a slave that never answers
        @(posedge clk); #1;
        m_cyc[M_DBG] = 1'b1;
        m_stb[M_DBG] = 1'b1;
        gq.push_back(M_DBG);
        eq.push_back(4'b1001);
        eq.push_back(4'b1001);
        wait_busy("t4_busy");
        fires = 0; f1 = 0; f2 = 0;
        for (int c = 1; c <= 33; c++) begin
            if (c > 1) @(negedge clk);
            if (timeout) begin
                fires++;
                if (fires == 1) f1 = c;
                else f2 = c;
            end
        end
        chk("t4_first", 64'(f1), 64'(16));
        chk("t4_second", 64'(f2), 64'(32));
        chk("t4_fires", 64'(fires), 64'(2));
        chk("t4_keep", 64'(busy), 64'(1));
        chk("t4_grant", 64'(grant), 64'(2));

        // ack on the 16th strobe cycle beats the watchdog
        @(posedge clk); #1 m_stb[M_DBG] = 1'b0;
        @(posedge clk); #1 m_stb[M_DBG] = 1'b1;
        repeat (15) @(posedge clk);
        #1;
        s_ack = 1'b1;
        s_dat_r = 32'h5555_AAAA;
        aq.push_back('{3'b100, 32'h5555_AAAA});
        @(negedge clk);
        chk("t5_noto", 64'(timeout), 64'(0));
        chk("t5_noerr", 64'(m_err), 64'(0));
        chk("t5_ack", 64'(m_ack), 64'b100);
        @(posedge clk); #1;
        s_ack = 1'b0;
        m_cyc[M_DBG] = 1'b0;
        m_stb[M_DBG] = 1'b0;
        @(posedge clk); #1;

        // reset in the middle of an m2 write
        m_cyc[M_LM32D] = 1'b1;
        m_stb[M_LM32D] = 1'b1;
        gq.push_back(M_LM32D);
        serve(M_LM32D, 32'h2222_2222, 1'b0);
        @(posedge clk); #1;
        m_cyc[M_DBG] = 1'b1;
        m_stb[M_DBG] = 1'b1;
        m_we[M_DBG] = 1'b1;
        m_adr[M_DBG*32 +: 32] = 32'h0000_2000;
        m_sel[M_DBG*4 +: 4] = 4'h3;
        m_dat_w[M_DBG*32 +: 32] = 32'hDEAD_BEEF;
        gq.push_back(M_DBG);
        wait_busy("t6_busy");
        chk("t6_we", 64'(s_we), 64'(1));
        chk("t6_sel", 64'(s_sel), 64'h3);
        chk("t6_datw", 64'(s_dat_w), 64'hDEAD_BEEF);
        chk("t6_adr", 64'(s_adr), 64'h2000);
        @(posedge clk); #1;
        reset = 1'b1;
        s_ack = 1'b1;
        s_dat_r = 32'h7777_7777;
        @(posedge clk); #1;
        reset = 1'b0;
        m_cyc[M_LM32I] = 1'b1;
        m_stb[M_LM32I] = 1'b1;
        gq.push_back(M_LM32I);
        gq.push_back(M_DBG);
        @(negedge clk);
        chk("t6_busy0", 64'(busy), 64'(0));
        chk("t6_scyc0", 64'(s_cyc), 64'(0));
        chk("t6_ack0", 64'(m_ack), 64'(0));
        @(posedge clk); #1;
        s_ack = 1'b0;
        serve(M_LM32I, 32'h3333_3333, 1'b0);
        serve(M_DBG, 32'h4444_4444, 1'b0);

        repeat (2) @(negedge clk);
        chk("gq_left", 64'(gq.size()), 64'(0));
        chk("aq_left", 64'(aq.size()), 64'(0));
        chk("eq_left", 64'(eq.size()), 64'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
